// File: rtl/mc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mc_ctrl_if                                                 |
// | Purpose : Bundles the multi-cycle controller's IR, ALU flag, memory  |
// |           handshake, datapath strobes/selects and status outputs.    |
// | Ports   : master = controller side (drives strobes/status),          |
// |           slave  = datapath side (drives Op/Funct/Zero/mem_ready).   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       EXTOp;
  logic [3:0]       ALUOp;
  logic [1:0]       ALUSrc;
  logic [1:0]       GPRSel;
  logic [1:0]       WDSel;
  logic [1:0]       NPCOp;
  logic [2:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic             bus_err;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
           EXTOp, ALUOp, ALUSrc, GPRSel, WDSel, NPCOp,
           state, instr_done, retired, illegal, bus_err
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
           EXTOp, ALUOp, ALUSrc, GPRSel, WDSel, NPCOp,
           state, instr_done, retired, illegal, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mc_ctrl                                                    |
// | Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the    |
// |           MIPS-subset CPU with memory-ready handshake, wait timeout, |
// |           illegal-opcode trap and retired-instruction counter.       |
// | Ports   : clk  - rising-edge clock                                   |
// |           rstn - asynchronous active-low reset                       |
// |           bus  - mc_ctrl_if.master (IR fields, Zero, mem_ready in;   |
// |                  strobes, selects, state and status out)             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mc_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 15,
  parameter int ILLEGAL_HALT = 1
) (
  input  wire logic  clk,
  input  wire logic  rstn,
  mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_t;

  localparam logic [3:0] c_ALU_NOP  = 4'b0000;
  localparam logic [3:0] c_ALU_ADD  = 4'b0001;
  localparam logic [3:0] c_ALU_SUB  = 4'b0010;
  localparam logic [3:0] c_ALU_AND  = 4'b0011;
  localparam logic [3:0] c_ALU_OR   = 4'b0100;
  localparam logic [3:0] c_ALU_SLT  = 4'b0101;
  localparam logic [3:0] c_ALU_SLTU = 4'b0110;
  localparam logic [3:0] c_ALU_NOR  = 4'b0111;
  localparam logic [3:0] c_ALU_SLL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRL  = 4'b1001;

  // Counter only needs to reach MEM_TIMEOUT-1; the timeout fires on the
  // MEM_TIMEOUT-th consecutive wait cycle.
  localparam int                  c_WAIT_W    = $clog2(MEM_TIMEOUT + 2);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
    c_WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             r_state, w_next;
  logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic [CNT_W-1:0]   r_retired;
  logic               r_illegal, r_bus_err;

  // Instruction decode
  logic       w_legal, w_imm_alu, w_lw, w_sw, w_beq, w_bne;
  logic       w_jr, w_jalr, w_j, w_jal;
  logic [3:0] w_alu_op;
  logic [1:0] w_alu_src, w_ext_op;

  // Raw FSM outputs (gated by reset below)
  logic       w_pc_write, w_ir_write, w_reg_write, w_mem_read, w_mem_write;
  logic       w_done, w_set_illegal, w_set_bus_err;
  logic [1:0] w_ext_sel, w_src_sel, w_gpr_sel, w_wd_sel, w_npc_sel;
  logic [3:0] w_alu_sel;
  logic       w_timeout;

  always_comb begin
    w_legal   = 1'b1;
    w_imm_alu = 1'b0;
    w_lw      = 1'b0;
    w_sw      = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_jr      = 1'b0;
    w_jalr    = 1'b0;
    w_j       = 1'b0;
    w_jal     = 1'b0;
    w_alu_op  = c_ALU_NOP;
    w_alu_src = 2'b00;
    w_ext_op  = 2'b00;
    case (bus.Op)
      6'b000000: begin
        case (bus.Funct)
          6'b100000, 6'b100001: w_alu_op = c_ALU_ADD;
          6'b100010, 6'b100011: w_alu_op = c_ALU_SUB;
          6'b100100: w_alu_op = c_ALU_AND;
          6'b100101: w_alu_op = c_ALU_OR;
          6'b100111: w_alu_op = c_ALU_NOR;
          6'b101010: w_alu_op = c_ALU_SLT;
          6'b101011: w_alu_op = c_ALU_SLTU;
          6'b000000: begin w_alu_op = c_ALU_SLL; w_alu_src = 2'b01; end
          6'b000010: begin w_alu_op = c_ALU_SRL; w_alu_src = 2'b01; end
          6'b000100: w_alu_op = c_ALU_SLL;
          6'b000110: w_alu_op = c_ALU_SRL;
          6'b001000: w_jr   = 1'b1;
          6'b001001: w_jalr = 1'b1;
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001000: begin w_imm_alu = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 2'b10; w_ext_op = 2'b01; end
      6'b001100: begin w_imm_alu = 1'b1; w_alu_op = c_ALU_AND; w_alu_src = 2'b10; end
      6'b001101: begin w_imm_alu = 1'b1; w_alu_op = c_ALU_OR;  w_alu_src = 2'b10; end
      6'b001010: begin w_imm_alu = 1'b1; w_alu_op = c_ALU_SLT; w_alu_src = 2'b10; w_ext_op = 2'b01; end
      6'b001111: begin w_imm_alu = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 2'b10; w_ext_op = 2'b10; end
      6'b100011: begin w_lw = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 2'b10; w_ext_op = 2'b01; end
      6'b101011: begin w_sw = 1'b1; w_alu_op = c_ALU_ADD; w_alu_src = 2'b10; w_ext_op = 2'b01; end
      6'b000100: begin w_beq = 1'b1; w_alu_op = c_ALU_SUB; end
      6'b000101: begin w_bne = 1'b1; w_alu_op = c_ALU_SUB; end
      6'b000010: w_j   = 1'b1;
      6'b000011: w_jal = 1'b1;
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_timeout = (MEM_TIMEOUT > 0) && (r_wait_cnt == c_WAIT_LAST);

  always_comb begin
    w_next        = r_state;
    w_wait_next   = '0;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_done        = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    w_ext_sel     = 2'b00;
    w_src_sel     = 2'b00;
    w_alu_sel     = c_ALU_NOP;
    w_gpr_sel     = 2'b00;
    w_wd_sel      = 2'b00;
    w_npc_sel     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (w_j || w_jal) begin
          w_pc_write = 1'b1;
          w_npc_sel  = 2'b10;
          w_done     = 1'b1;
          w_next     = S_FETCH;
          if (w_jal) begin
            w_reg_write = 1'b1;
            w_gpr_sel   = 2'b10;
            w_wd_sel    = 2'b10;
          end
        end else if (!w_legal) begin
          w_set_illegal = 1'b1;
          if (ILLEGAL_HALT != 0) begin
            w_next = S_HALT;
          end else begin
            w_done = 1'b1;
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_sel = w_alu_op;
        w_src_sel = w_alu_src;
        w_ext_sel = w_ext_op;
        if (w_beq || w_bne) begin
          w_pc_write = (w_beq && bus.Zero) || (w_bne && !bus.Zero);
          w_npc_sel  = 2'b01;
          w_done     = 1'b1;
          w_next     = S_FETCH;
        end else if (w_jr || w_jalr) begin
          w_pc_write = 1'b1;
          w_npc_sel  = 2'b11;
          w_done     = 1'b1;
          w_next     = S_FETCH;
          if (w_jalr) begin
            w_reg_write = 1'b1;
            w_wd_sel    = 2'b10;
          end
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_alu_sel   = w_alu_op;
        w_src_sel   = w_alu_src;
        w_ext_sel   = w_ext_op;
        w_mem_read  = w_lw;
        w_mem_write = w_sw;
        if (bus.mem_ready) begin
          if (w_lw) begin
            w_next = S_WB;
          end else begin
            w_done = 1'b1;
            w_next = S_FETCH;
          end
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_next = r_wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        w_alu_sel   = w_alu_op;
        w_src_sel   = w_alu_src;
        w_ext_sel   = w_ext_op;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_gpr_sel   = (w_lw || w_imm_alu) ? 2'b01 : 2'b00;
        w_wd_sel    = w_lw ? 2'b01 : 2'b00;
        w_next      = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_retired  <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_done)        r_retired <= r_retired + 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  // The state register resets to FETCH, whose decode asserts MemRead; gate
  // every output with rstn so nothing is driven while reset is held.
  assign bus.PCWrite    = rstn & w_pc_write;
  assign bus.IRWrite    = rstn & w_ir_write;
  assign bus.RegWrite   = rstn & w_reg_write;
  assign bus.MemRead    = rstn & w_mem_read;
  assign bus.MemWrite   = rstn & w_mem_write;
  assign bus.instr_done = rstn & w_done;
  assign bus.EXTOp      = rstn ? w_ext_sel : 2'b00;
  assign bus.ALUOp      = rstn ? w_alu_sel : 4'b0000;
  assign bus.ALUSrc     = rstn ? w_src_sel : 2'b00;
  assign bus.GPRSel     = rstn ? w_gpr_sel : 2'b00;
  assign bus.WDSel      = rstn ? w_wd_sel  : 2'b00;
  assign bus.NPCOp      = rstn ? w_npc_sel : 2'b00;
  assign bus.state      = r_state;
  assign bus.retired    = r_retired;
  assign bus.illegal    = r_illegal;
  assign bus.bus_err    = r_bus_err;

endmodule
`default_nettype wire
